// File: rtl/em_feeder_pkg.sv
// Shared types and sizing for the energy-monitor stream feeder.
// Default geometry matches a 256-spin, 4-bit-weight monitor.
package em_feeder_pkg;

  localparam int EM_NUM_SPIN = 256;
  localparam int EM_BITDATA  = 4;
  localparam int EM_ADDR_BIT = 8;
  localparam int EM_DATAW    = EM_NUM_SPIN * EM_BITDATA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMCFG,
    S_SPIN,
    S_WEIGHT,
    S_WAIT
  } state_t;

  // Row counters need one extra bit so N = NUM_SPIN fits.
  function automatic int cnt_bits(input int idx_bits);
    return idx_bits + 1;
  endfunction

endpackage

// File: rtl/em_feeder_fifo.sv
// Two-entry weight-row buffer between the SRAM read port and the
// monitor's weight handshake.
module em_feeder_fifo
  import em_feeder_pkg::*;
#(
  parameter int DW = EM_DATAW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] r_mem [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_occ;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = pop_i && (r_occ != 2'd0);
  assign w_push = push_i && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign dout_o  = r_mem[r_rp];
  assign full_o  = (r_occ == 2'd2);
  assign empty_o = (r_occ == 2'd0);
  assign occ_o   = r_occ;

endmodule

// File: rtl/em_stream_feeder.sv
// Transmit sequencer: counter config, spin vector, then N weight rows
// prefetched from a 1-cycle SRAM, then wait for the monitor's finish.
module em_stream_feeder
  import em_feeder_pkg::*;
#(
  parameter int NUM_SPIN    = EM_NUM_SPIN,
  parameter int BITDATA     = EM_BITDATA,
  parameter int SPINIDX_BIT = $clog2(NUM_SPIN),
  parameter int ADDR_BIT    = EM_ADDR_BIT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [SPINIDX_BIT-1:0]       cfg_count_i,
  input  logic [ADDR_BIT-1:0]          cfg_base_i,
  input  logic [NUM_SPIN-1:0]          cfg_spin_i,
  output logic                         em_cfg_valid_o,
  input  logic                         em_cfg_ready_i,
  output logic [SPINIDX_BIT-1:0]       em_cfg_count_o,
  output logic                         spin_valid_o,
  input  logic                         spin_ready_i,
  output logic [NUM_SPIN-1:0]          spin_o,
  output logic                         weight_valid_o,
  input  logic                         weight_ready_i,
  output logic [NUM_SPIN*BITDATA-1:0]  weight_o,
  input  logic                         em_finish_i,
  output logic                         mem_req_o,
  output logic [ADDR_BIT-1:0]          mem_addr_o,
  input  logic [NUM_SPIN*BITDATA-1:0]  mem_rdata_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int DATAW = NUM_SPIN * BITDATA;
  localparam int CNTW  = cnt_bits(SPINIDX_BIT);

  state_t                 r_state;
  state_t                 w_next;
  logic [SPINIDX_BIT-1:0] r_count;
  logic [ADDR_BIT-1:0]    r_base;
  logic [NUM_SPIN-1:0]    r_spin;
  logic [CNTW-1:0]        r_req;
  logic [CNTW-1:0]        r_sent;
  logic [CNTW-1:0]        w_last_idx;
  logic                   r_inflight;
  logic                   r_done;

  logic                   w_cfg_fire;
  logic                   w_fetch;
  logic                   w_room;
  logic                   w_req;
  logic                   w_wvalid;
  logic                   w_wfire;
  logic                   w_last;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [1:0]             w_occ;
  logic [DATAW-1:0]       w_head;

  assign w_last_idx = {1'b0, r_count};
  assign w_cfg_fire = (r_state == S_IDLE) && cfg_valid_i;
  assign w_fetch    = (r_state == S_SPIN) || (r_state == S_WEIGHT);
  assign w_room     = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2;
  assign w_req      = w_fetch && (r_req <= w_last_idx)
                    && w_room && !w_full;

  // The read returning this cycle can be handed straight to the monitor
  // when the buffer is empty; that keeps one row per cycle.
  assign w_wvalid = (r_state == S_WEIGHT) && (!w_empty || r_inflight);
  assign w_wfire  = w_wvalid && weight_ready_i;
  assign w_last   = w_wfire && (r_sent == w_last_idx);
  assign w_pop    = w_wfire && !w_empty;
  assign w_push   = r_inflight && !(w_wfire && w_empty);

  em_feeder_fifo #(
    .DW(DATAW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (mem_rdata_i),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .occ_o   (w_occ)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_base     <= '0;
      r_spin     <= '0;
      r_req      <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_req;
      r_done     <= (r_state == S_WAIT) && em_finish_i;
      if (w_cfg_fire) begin
        r_count <= cfg_count_i;
        r_base  <= cfg_base_i;
        r_spin  <= cfg_spin_i;
        r_req   <= '0;
        r_sent  <= '0;
      end else begin
        if (w_req)   r_req  <= r_req + CNTW'(1);
        if (w_wfire) r_sent <= r_sent + CNTW'(1);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    cfg_ready_o    = 1'b0;
    em_cfg_valid_o = 1'b0;
    spin_valid_o   = 1'b0;
    busy_o         = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cfg_valid_i) w_next = S_EMCFG;
      end
      S_EMCFG: begin
        em_cfg_valid_o = 1'b1;
        if (em_cfg_ready_i) w_next = S_SPIN;
      end
      S_SPIN: begin
        spin_valid_o = 1'b1;
        if (spin_ready_i) w_next = S_WEIGHT;
      end
      S_WEIGHT: begin
        if (w_last) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (em_finish_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign em_cfg_count_o = r_count;
  assign spin_o         = r_spin;
  assign weight_valid_o = w_wvalid;
  assign weight_o       = !w_wvalid ? '0 :
                          (w_empty ? mem_rdata_i : w_head);
  assign mem_req_o      = w_req;
  assign mem_addr_o     = w_req ? r_base + ADDR_BIT'(r_req) : '0;
  assign done_o         = r_done;

endmodule

// File: tb/tb_em_stream_feeder.sv
// Directed/randomized bench for em_stream_feeder with an SRAM model
// and a transaction-level reference of addresses, rows and latencies.
module tb_em_stream_feeder;

  localparam int NS = 256;
  localparam int BD = 4;
  localparam int SB = 8;
  localparam int AB = 8;
  localparam int DW = NS * BD;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [SB-1:0] cfg_count_i;
  logic [AB-1:0] cfg_base_i;
  logic [NS-1:0] cfg_spin_i;
  logic          em_cfg_valid_o;
  logic          em_cfg_ready_i;
  logic [SB-1:0] em_cfg_count_o;
  logic          spin_valid_o;
  logic          spin_ready_i;
  logic [NS-1:0] spin_o;
  logic          weight_valid_o;
  logic          weight_ready_i;
  logic [DW-1:0] weight_o;
  logic          em_finish_i;
  logic          mem_req_o;
  logic [AB-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  em_stream_feeder #(
    .NUM_SPIN(NS), .BITDATA(BD), .SPINIDX_BIT(SB), .ADDR_BIT(AB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_count_i(cfg_count_i), .cfg_base_i(cfg_base_i),
    .cfg_spin_i(cfg_spin_i),
    .em_cfg_valid_o(em_cfg_valid_o), .em_cfg_ready_i(em_cfg_ready_i),
    .em_cfg_count_o(em_cfg_count_o),
    .spin_valid_o(spin_valid_o), .spin_ready_i(spin_ready_i),
    .spin_o(spin_o),
    .weight_valid_o(weight_valid_o), .weight_ready_i(weight_ready_i),
    .weight_o(weight_o), .em_finish_i(em_finish_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] sram [256];

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NS-1:0] rnd_spin();
    logic [NS-1:0] v;
    for (int k = 0; k < NS / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // 1-cycle SRAM; garbage on the bus whenever no read was issued
  always @(posedge clk)
    mem_rdata_i <= mem_req_o ? sram[mem_addr_o] : rnd_row();

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // transaction log filled by the monitor
  int            t0 = 0;
  int            acc_q [$];
  int            req_c [$];
  logic [AB-1:0] req_a [$];
  int            w_c [$];
  logic [DW-1:0] w_d [$];
  int            done_q [$];
  int            emcfg_c = -1;
  int            spin_c = -1;
  logic [SB-1:0] m_cnt;
  logic [NS-1:0] m_spin;
  int            nreq = 0;
  int            nwt = 0;
  bit            spin_seen = 0;
  bit            p_wv = 0, p_wr = 0, p_ev = 0, p_er = 0;
  bit            p_sv = 0, p_sr = 0;
  logic [DW-1:0] p_wd;
  logic [SB-1:0] p_cnt;
  logic [NS-1:0] p_sp;

  always @(negedge clk) begin
    if (rst_i) begin
      nreq = 0; nwt = 0; spin_seen = 0;
      p_wv = 0; p_ev = 0; p_sv = 0;
    end else begin
      if (cfg_valid_i && cfg_ready_o) begin
        t0 = cyc; acc_q.push_back(cyc);
        nreq = 0; nwt = 0; spin_seen = 0;
      end
      if (em_cfg_valid_o && em_cfg_ready_i) begin
        emcfg_c = cyc - t0; m_cnt = em_cfg_count_o;
      end
      if (spin_valid_o && spin_ready_i) begin
        spin_c = cyc - t0; m_spin = spin_o; spin_seen = 1;
      end
      if (mem_req_o) begin
        req_c.push_back(cyc - t0); req_a.push_back(mem_addr_o);
        nreq++;
      end
      if (weight_valid_o && weight_ready_i) begin
        w_c.push_back(cyc - t0); w_d.push_back(weight_o);
        nwt++;
      end
      if (done_o) begin
        done_q.push_back(cyc);
        chk("done_with_cfg_ready", cfg_ready_o, 1);
      end
      if (weight_valid_o) chk("weight_before_spin", spin_seen, 1);
      if (busy_o) chk("outstanding_le2", (nreq - nwt) <= 2, 1);
      chk("ready_vs_busy", cfg_ready_o, !busy_o);
      if (p_wv && !p_wr) begin
        chk("weight_valid_held", weight_valid_o, 1);
        chk("weight_data_held", weight_o === p_wd, 1);
      end
      if (p_ev && !p_er) begin
        chk("emcfg_valid_held", em_cfg_valid_o, 1);
        chk("emcfg_count_held", em_cfg_count_o, p_cnt);
      end
      if (p_sv && !p_sr) begin
        chk("spin_valid_held", spin_valid_o, 1);
        chk("spin_data_held", spin_o === p_sp, 1);
      end
      p_wv = weight_valid_o; p_wr = weight_ready_i; p_wd = weight_o;
      p_ev = em_cfg_valid_o; p_er = em_cfg_ready_i;
      p_cnt = em_cfg_count_o;
      p_sv = spin_valid_o; p_sr = spin_ready_i; p_sp = spin_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    acc_q.delete(); req_c.delete(); req_a.delete();
    w_c.delete(); w_d.delete(); done_q.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_emcfg_valid"}, em_cfg_valid_o, 0);
    chk({tag, "_spin_valid"}, spin_valid_o, 0);
    chk({tag, "_weight_valid"}, weight_valid_o, 0);
    chk({tag, "_weight_zero"}, weight_o === '0, 1);
    chk({tag, "_spin_zero"}, spin_o === '0, 1);
    chk({tag, "_count_zero"}, em_cfg_count_o, 0);
  endtask

  task automatic start_job(input int n, input logic [AB-1:0] base,
                           input logic [NS-1:0] sp);
    bit ok = 0;
    cfg_valid_i = 1; cfg_count_i = SB'(n - 1);
    cfg_base_i = base; cfg_spin_i = sp;
    for (int k = 0; k < 50; k++) begin
      if (cfg_ready_o) begin ok = 1; tick(); break; end
      tick();
    end
    chk("cfg_accept_timeout", ok, 1);
    cfg_valid_i = 0;
  endtask

  task automatic wait_rows(input int n, input int lim);
    bit ok = 0;
    for (int k = 0; k < lim; k++) begin
      tick();
      if (w_d.size() >= n) begin ok = 1; break; end
    end
    chk("rows_timeout", ok, 1);
  endtask

  task automatic finish_job(input string tag, input int n,
                            input bit timing);
    int ts = t0;
    int fin;
    em_finish_i = 1; fin = cyc;
    tick();
    em_finish_i = 0;
    tick();
    chk({tag, "_done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) begin
      chk({tag, "_done_lat"}, done_q[0], fin + 1);
      if (timing) chk({tag, "_done_from_cfg"}, done_q[0] - ts, n + 4);
    end
    chk({tag, "_done_pulse"}, done_o, 0);
  endtask

  task automatic check_job(input string tag, input int n,
                           input logic [AB-1:0] base,
                           input logic [NS-1:0] sp, input bit timing);
    int ba = 0, bd = 0, bc = 0;
    logic [AB-1:0] a;
    chk({tag, "_nreq"}, req_a.size(), n);
    chk({tag, "_nrows"}, w_d.size(), n);
    for (int i = 0; i < n; i++) begin
      a = base + AB'(i);
      if (i < req_a.size()) begin
        if (req_a[i] !== a) ba++;
        if (timing && req_c[i] != 2 + i) bc++;
      end
      if (i < w_d.size()) begin
        if (w_d[i] !== sram[a]) bd++;
        if (timing && w_c[i] != 3 + i) bc++;
      end
    end
    chk({tag, "_addr_bad"}, ba, 0);
    chk({tag, "_row_bad"}, bd, 0);
    chk({tag, "_emcfg_count"}, m_cnt, n - 1);
    chk({tag, "_spin_vec"}, m_spin === sp, 1);
    if (timing) begin
      chk({tag, "_emcfg_cyc"}, emcfg_c, 1);
      chk({tag, "_spin_cyc"}, spin_c, 2);
      chk({tag, "_cycle_bad"}, bc, 0);
    end
  endtask

  task automatic run_full(input string tag, input int n,
                          input logic [AB-1:0] base);
    logic [NS-1:0] sp = rnd_spin();
    clr();
    start_job(n, base, sp);
    wait_rows(n, n + 20);
    finish_job(tag, n, 1);
    check_job(tag, n, base, sp, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] sp;
    logic [NS-1:0] sp2;
    logic [AB-1:0] b;
    logic [AB-1:0] b2;
    rst_i = 1; cfg_valid_i = 0; cfg_count_i = '0;
    cfg_base_i = '0; cfg_spin_i = '0;
    em_cfg_ready_i = 1; spin_ready_i = 1; weight_ready_i = 1;
    em_finish_i = 0;
    for (int i = 0; i < 256; i++) sram[i] = rnd_row();
    repeat (3) tick();
    rst_i = 0;
    tick();
    check_idle("reset");

    run_full("n4", 4, 8'h10);
    run_full("n3_wrap", 3, 8'hFE);

    // weight_ready low for 5 cycles after two rows
    sp = rnd_spin(); b = AB'($urandom);
    clr();
    start_job(6, b, sp);
    wait_rows(2, 20);
    weight_ready_i = 0;
    repeat (5) tick();
    chk("stall_reqs", req_a.size(), 4);
    chk("stall_valid", weight_valid_o, 1);
    chk("stall_head", weight_o === sram[b + AB'(2)], 1);
    weight_ready_i = 1;
    wait_rows(6, 40);
    finish_job("stall", 6, 0);
    check_job("stall", 6, b, sp, 0);

    // slow em_cfg/spin readies; finish pulse during SPIN
    sp = rnd_spin(); b = AB'($urandom);
    em_cfg_ready_i = 0; spin_ready_i = 0;
    clr();
    start_job(3, b, sp);
    repeat (3) tick();
    em_cfg_ready_i = 1;
    tick();
    em_finish_i = 1;
    tick();
    em_finish_i = 0;
    repeat (2) tick();
    spin_ready_i = 1;
    wait_rows(3, 30);
    chk("slow_finish_ignored", done_q.size(), 0);
    chk("slow_emcfg_cyc", emcfg_c, 4);
    chk("slow_spin_cyc", spin_c, 8);
    if (req_c.size() > 0) chk("slow_first_req", req_c[0], 5);
    if (w_c.size() > 0) chk("slow_first_row", w_c[0], 9);
    finish_job("slow", 3, 0);
    check_job("slow", 3, b, sp, 0);

    // reset in the middle of an 8-row job
    clr();
    start_job(8, AB'($urandom), rnd_spin());
    wait_rows(2, 20);
    rst_i = 1;
    tick();
    rst_i = 0;
    check_idle("mid_reset");
    chk("mid_reset_no_done", done_q.size(), 0);
    chk("mid_reset_partial", w_d.size() < 8, 1);
    tick();
    run_full("n1_after_rst", 1, AB'($urandom));

    // full-size job with a second job waiting at the door
    sp = rnd_spin(); b = AB'($urandom);
    sp2 = rnd_spin(); b2 = AB'($urandom);
    clr();
    start_job(256, b, sp);
    repeat (5) tick();
    cfg_valid_i = 1; cfg_count_i = 8'd1;
    cfg_base_i = b2; cfg_spin_i = sp2;
    chk("busy_cfg_ready_low", cfg_ready_o, 0);
    wait_rows(256, 320);
    check_job("n256", 256, b, sp, 1);
    finish_job("n256", 256, 1);
    chk("second_acc_count", acc_q.size(), 2);
    if (acc_q.size() > 1 && done_q.size() > 0)
      chk("second_acc_at_done", acc_q[1], done_q[0]);
    cfg_valid_i = 0;
    clr();
    wait_rows(2, 20);
    finish_job("second", 2, 1);
    check_job("second", 2, b2, sp2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/em_stream_feeder.md
# em_stream_feeder

Transmit-side sequencer for the energy monitor. It accepts one job: a spin vector, a row count and a weight base address. It then drives the energy monitor's three input handshakes in protocol order: counter config, one spin transfer, then N weight-row transfers. Weight rows are prefetched from a 1-cycle-latency weight SRAM through a 2-entry buffer. After the last row it waits for the monitor's finish flag and reports job completion to the host/controller.

## Interface
Parameters:
- NUM_SPIN, 256, spins per vector; also the max rows per job.
- BITDATA, 4, bits per weight element.
- SPINIDX_BIT, $clog2(NUM_SPIN), row-count width.
- ADDR_BIT, 8, weight SRAM address width.
- DATAW (derived), NUM_SPIN*BITDATA, weight row width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_valid_i / cfg_ready_o  in/out  1  host job handshake.
- cfg_count_i  in  SPINIDX_BIT  rows minus one; N = cfg_count_i+1, range 1..NUM_SPIN.
- cfg_base_i  in  ADDR_BIT  SRAM address of row 0.
- cfg_spin_i  in  NUM_SPIN  spin vector.
- em_cfg_valid_o / em_cfg_ready_i  out/in  1  monitor counter-config handshake.
- em_cfg_count_o  out  SPINIDX_BIT  latched cfg_count_i.
- spin_valid_o / spin_ready_i  out/in  1  spin handshake.
- spin_o  out  NUM_SPIN  latched spin vector.
- weight_valid_o / weight_ready_i  out/in  1  weight-row handshake.
- weight_o  out  DATAW  buffer head.
- em_finish_i  in  1  monitor finish flag, level.
- mem_req_o  out  1  SRAM read request.
- mem_addr_o  out  ADDR_BIT  SRAM read address.
- mem_rdata_i  in  DATAW  read data, valid exactly 1 cycle after mem_req_o; no backpressure.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle job-complete pulse.

## Operation
FSM states: IDLE → EMCFG → SPIN → WEIGHT → WAIT → IDLE.

- **IDLE:**
  - cfg_ready_o=1.
  - On cfg_valid_i: latch count, base and spin; clear the row counters; go to EMCFG.
- **EMCFG:**
  - em_cfg_valid_o=1.
  - On em_cfg_ready_i: go to SPIN.
- **SPIN:**
  - spin_valid_o=1.
  - On spin_ready_i: go to WEIGHT.
  - SRAM prefetch starts on entry to SPIN.
- **WEIGHT:**
  - weight_valid_o = buffer non-empty.
  - Each weight handshake pops the buffer and increments the sent counter.
  - On the N-th handshake: go to WAIT.
- **WAIT:**
  - On em_finish_i=1: go to IDLE and pulse done_o.
  - em_finish_i is ignored in all other states.

Prefetch rules:
- Request counter r runs 0..N-1; mem_addr_o = cfg_base + r, modulo 2^ADDR_BIT (wrap allowed).
- mem_req_o is asserted only in SPIN/WEIGHT, only while r<N, and only while (buffer occupancy + in-flight reads) < 2.
- Read data is pushed into the buffer the cycle after the request. Overflow is therefore impossible.

Handshake rules:
- A valid, once raised, stays high with stable data until its ready is seen.
- A transfer occurs in any cycle with valid && ready.
- Downstream readies may be high before valid; no combinational ready→valid path.

Reset:
- Reset mid-job returns to IDLE, empties the buffer and drops the in-flight read. No done_o is issued.

## Timing
- Reset values: cfg_ready_o=1 (IDLE); all other outputs 0, including busy_o, done_o, mem_req_o and all valids.
- Latency with all readies high, cfg accepted at cycle 0:
  - em_cfg transfer at cycle 1.
  - spin transfer at cycle 2.
  - mem_req_o at cycles 2..N+1.
  - weight transfers at cycles 3..N+2, one row per cycle (full throughput).
  - WAIT from cycle N+3.
- done_o is registered: it rises the cycle after em_finish_i is sampled high in WAIT, together with cfg_ready_o=1.
- weight_ready_i low stalls the stream. At most 2 rows are buffered; requests resume the cycle after a pop.
- N=1: a single request, transfer and pop, then WAIT.
- N=NUM_SPIN: the counters must not overflow. r and the sent counter are SPINIDX_BIT+1 wide.
- cfg_valid_i arriving while busy: it is not accepted (cfg_ready_o=0) and is held by the host.

## Structure
- Package em_feeder_pkg holds:
  - the state enum (IDLE, EMCFG, SPIN, WEIGHT, WAIT);
  - localparams for DATAW and the counter widths.
- Sub-module em_feeder_fifo: 2-entry DATAW-wide FIFO with push, pop, full, empty and occupancy.
- Top holds the FSM, the request/sent counters, the in-flight flag and the config latches.

## Test plan
- N=4, base=0x10, all readies high → mem_addr 0x10..0x13 on cycles 2–5; weight rows equal SRAM contents in order on cycles 3–6; done_o one cycle after em_finish_i.
- N=3, base=0xFE → addresses 0xFE, 0xFF, 0x00 (wrap); rows delivered correctly.
- weight_ready_i held low for 5 cycles mid-stream → at most 2 reads outstanding/buffered, weight_o stable while stalled, no row lost or duplicated.
- em_cfg_ready_i and spin_ready_i delayed 3 cycles each → valids held with stable em_cfg_count_o/spin_o; no weight_valid_o before the spin transfer; em_finish_i pulsed in SPIN is ignored.
- rst_i asserted in WEIGHT after 2 of 8 rows → next cycle all outputs at reset values; a new job with N=1 runs cleanly.
- N=NUM_SPIN (cfg_count_i=255) → exactly 256 weight transfers, then WAIT; second cfg_valid_i during the job is not accepted until done_o.
